// File: rtl/bullet_pkg.sv
// Bullet RAM layout, region constants, limits and spawn FSM states,
// shared between the spawner and the drawing engine.
package bullet_pkg;

  localparam logic [7:0] OFF_STATUS = 8'd0;
  localparam logic [7:0] OFF_MOVE   = 8'd1;
  localparam logic [7:0] OFF_X      = 8'd2;
  localparam logic [7:0] OFF_Y      = 8'd3;

  localparam logic [7:0] STATUS_ACTIVE = 8'h01;

  localparam int unsigned DEF_PLAYER_SLOTS = 48;
  localparam int unsigned DEF_ENEMY_SLOTS  = 16;
  localparam int unsigned DEF_X_MAX        = 159;
  localparam int unsigned DEF_Y_MAX        = 119;

  localparam logic [7:0] PLAYER_BASE = 8'd0;
  localparam logic [7:0] ENEMY_BASE  = 8'(4 * DEF_PLAYER_SLOTS);

  localparam int MOVE_PX = 3;
  localparam int MOVE_NX = 2;
  localparam int MOVE_PY = 1;
  localparam int MOVE_NY = 0;

  typedef enum logic [3:0] {
    IDLE, RD, WT, CK, WMOV, WX, WY, WACT, DONE
  } spawn_state_e;

  function automatic logic [7:0] region_base(
    input logic        enemy,
    input int unsigned pslots
  );
    return enemy ? 8'(4 * pslots) : PLAYER_BASE;
  endfunction

  function automatic logic [7:0] slot_addr(
    input logic [7:0] base,
    input logic [5:0] idx,
    input logic [7:0] off
  );
    return base + {idx, 2'b00} + off;
  endfunction

endpackage

// File: rtl/spawn_bullets_if.sv
// Spawn request / completion handshake and bullet RAM bus.
// master = requester + RAM, slave = spawn_bullets.
interface spawn_bullets_if;

  logic       begin_spawn;
  logic       spawn_enemy;
  logic [7:0] spawn_x;
  logic [6:0] spawn_y;
  logic [3:0] spawn_move;
  logic [7:0] DataOut;

  logic [7:0] address;
  logic [7:0] WriteData;
  logic       RamWrite;
  logic       done;
  logic       fail;
  logic [5:0] slot;

  modport master (
    output begin_spawn, spawn_enemy, spawn_x, spawn_y,
    output spawn_move, DataOut,
    input  address, WriteData, RamWrite, done, fail, slot
  );

  modport slave (
    input  begin_spawn, spawn_enemy, spawn_x, spawn_y,
    input  spawn_move, DataOut,
    output address, WriteData, RamWrite, done, fail, slot
  );

endinterface

// File: rtl/bullet_slot_ptr.sv
// Slot scan index, region base/limit select and per-region scan origin.
// SPAWN_ROTATE_EN: origin follows last allocation, search wraps once.
module bullet_slot_ptr
  import bullet_pkg::*;
#(
  parameter int unsigned PLAYER_SLOTS = DEF_PLAYER_SLOTS,
  parameter int unsigned ENEMY_SLOTS  = DEF_ENEMY_SLOTS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       enemy_in,
  input  logic       adv,
  input  logic       commit,
  output logic [5:0] idx,
  output logic [5:0] nxt_idx,
  output logic [5:0] abs_slot,
  output logic [7:0] base,
  output logic [7:0] nxt_base,
  output logic       last
);

  localparam logic [6:0] P_N = 7'(PLAYER_SLOTS);
  localparam logic [6:0] E_N = 7'(ENEMY_SLOTS);

  logic       enemy_q, enemy_d;
  logic [5:0] idx_q, idx_d;
  logic [6:0] lim, inc;

`ifdef SPAWN_ROTATE_EN
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] org_p_q, org_p_d;
  logic [5:0] org_e_q, org_e_d;
  logic [5:0] wrap;
`else
  logic unused_commit;
  assign unused_commit = commit;
`endif

  always_comb begin
    lim     = enemy_q ? E_N : P_N;
    inc     = {1'b0, idx_q} + 7'd1;
    enemy_d = load ? enemy_in : enemy_q;
    idx_d   = idx_q;
`ifdef SPAWN_ROTATE_EN
    wrap    = (inc == lim) ? 6'd0 : inc[5:0];
    cnt_d   = cnt_q;
    org_p_d = org_p_q;
    org_e_d = org_e_q;
    if (load) begin
      idx_d = enemy_in ? org_e_q : org_p_q;
      cnt_d = 6'd0;
    end else if (adv) begin
      idx_d = wrap;
      cnt_d = cnt_q + 6'd1;
    end
    if (commit) begin
      if (enemy_q) org_e_d = wrap;
      else         org_p_d = wrap;
    end
    // Count scanned slots, not index, so a wrapped search stops after one lap
    last = ({1'b0, cnt_q} + 7'd1) == lim;
`else
    if (load)     idx_d = 6'd0;
    else if (adv) idx_d = inc[5:0];
    last = (inc == lim);
`endif
  end

  assign idx      = idx_q;
  assign nxt_idx  = idx_d;
  assign base     = region_base(enemy_q, PLAYER_SLOTS);
  assign nxt_base = region_base(enemy_d, PLAYER_SLOTS);
  assign abs_slot = idx_q + (enemy_q ? P_N[5:0] : 6'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enemy_q <= 1'b0;
      idx_q   <= 6'd0;
`ifdef SPAWN_ROTATE_EN
      cnt_q   <= 6'd0;
      org_p_q <= 6'd0;
      org_e_q <= 6'd0;
`endif
    end else begin
      enemy_q <= enemy_d;
      idx_q   <= idx_d;
`ifdef SPAWN_ROTATE_EN
      cnt_q   <= cnt_d;
      org_p_q <= org_p_d;
      org_e_q <= org_e_d;
`endif
    end
  end

endmodule

// File: rtl/spawn_bullets.sv
// Finds a free bullet slot and initialises it, status byte written last.
// SPAWN_ROTATE_EN (in bullet_slot_ptr) enables rotating scan origin.
module spawn_bullets
  import bullet_pkg::*;
#(
  parameter int unsigned PLAYER_SLOTS = DEF_PLAYER_SLOTS,
  parameter int unsigned ENEMY_SLOTS  = DEF_ENEMY_SLOTS,
  parameter int unsigned X_MAX        = DEF_X_MAX,
  parameter int unsigned Y_MAX        = DEF_Y_MAX
) (
  input  logic           clk,
  input  logic           reset,
  spawn_bullets_if.slave bus
);

  spawn_state_e state_q, state_d;
  logic [7:0]   addr_q, addr_d;
  logic [7:0]   wdata_q, wdata_d;
  logic         we_q, we_d;
  logic         done_q, done_d;
  logic         fail_q, fail_d;
  logic [5:0]   slot_q, slot_d;
  logic [3:0]   move_q, move_d;
  logic [7:0]   x_q, x_d;
  logic [6:0]   y_q, y_d;

  logic       ptr_load, ptr_adv, ptr_commit, ptr_last;
  logic [5:0] idx, nxt_idx, abs_slot;
  logic [7:0] base, nxt_base;
  logic       bad_xy;
  logic       unused_rd;

  assign unused_rd = ^bus.DataOut[7:1];
  assign bad_xy = (bus.spawn_x > 8'(X_MAX)) ||
                  (bus.spawn_y > 7'(Y_MAX));

  bullet_slot_ptr #(
    .PLAYER_SLOTS (PLAYER_SLOTS),
    .ENEMY_SLOTS  (ENEMY_SLOTS)
  ) u_ptr (
    .clk      (clk),
    .rst      (reset),
    .load     (ptr_load),
    .enemy_in (bus.spawn_enemy),
    .adv      (ptr_adv),
    .commit   (ptr_commit),
    .idx      (idx),
    .nxt_idx  (nxt_idx),
    .abs_slot (abs_slot),
    .base     (base),
    .nxt_base (nxt_base),
    .last     (ptr_last)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    done_d     = done_q;
    fail_d     = fail_q;
    slot_d     = slot_q;
    move_d     = move_q;
    x_d        = x_q;
    y_d        = y_q;
    ptr_load   = 1'b0;
    ptr_adv    = 1'b0;
    ptr_commit = 1'b0;
    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        fail_d = 1'b0;
        if (bus.begin_spawn) begin
          move_d = bus.spawn_move;
          x_d    = bus.spawn_x;
          y_d    = bus.spawn_y;
          if (bad_xy) begin
            state_d = DONE;
            done_d  = 1'b1;
            fail_d  = 1'b1;
          end else begin
            ptr_load = 1'b1;
            state_d  = RD;
            addr_d   = slot_addr(nxt_base, nxt_idx, OFF_STATUS);
          end
        end
      end
      RD: state_d = WT;
      WT: state_d = CK;
      CK: begin
        if (bus.DataOut[0]) begin
          if (ptr_last) begin
            state_d = DONE;
            done_d  = 1'b1;
            fail_d  = 1'b1;
          end else begin
            ptr_adv = 1'b1;
            state_d = RD;
            addr_d  = slot_addr(nxt_base, nxt_idx, OFF_STATUS);
          end
        end else begin
          state_d = WMOV;
          addr_d  = slot_addr(base, idx, OFF_MOVE);
          wdata_d = {4'b0, move_q};
          we_d    = 1'b1;
        end
      end
      WMOV: begin
        state_d = WX;
        addr_d  = slot_addr(base, idx, OFF_X);
        wdata_d = x_q;
        we_d    = 1'b1;
      end
      WX: begin
        state_d = WY;
        addr_d  = slot_addr(base, idx, OFF_Y);
        wdata_d = {1'b0, y_q};
        we_d    = 1'b1;
      end
      // Status goes last so the drawer never sees a half-built bullet
      WY: begin
        state_d = WACT;
        addr_d  = slot_addr(base, idx, OFF_STATUS);
        wdata_d = STATUS_ACTIVE;
        we_d    = 1'b1;
      end
      WACT: begin
        state_d    = DONE;
        done_d     = 1'b1;
        fail_d     = 1'b0;
        slot_d     = abs_slot;
        ptr_commit = 1'b1;
      end
      DONE: begin
        if (!bus.begin_spawn) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      slot_q  <= 6'd0;
      move_q  <= 4'd0;
      x_q     <= 8'd0;
      y_q     <= 7'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      slot_q  <= slot_d;
      move_q  <= move_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign bus.address   = addr_q;
  assign bus.WriteData = wdata_q;
  assign bus.RamWrite  = we_q;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
  assign bus.slot      = slot_q;

endmodule

// File: tb/tb_spawn_bullets.sv
// Randomized bench for spawn_bullets against a slot-search reference model.
// Honors SPAWN_ROTATE_EN in the model when the build defines it.
module tb_spawn_bullets;

  localparam int PS = 48;
  localparam int ES = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;

  spawn_bullets_if bus();

  spawn_bullets #(
    .PLAYER_SLOTS (PS),
    .ENEMY_SLOTS  (ES),
    .X_MAX        (159),
    .Y_MAX        (119)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [256];
  logic [7:0]  img [256];
  logic        load_req = 1'b0;
  logic [15:0] wlog [$];

  always @(posedge clk) begin
    if (load_req) mem <= img;
    else if (bus.RamWrite) begin
      mem[bus.address] <= bus.WriteData;
      wlog.push_back({bus.address, bus.WriteData});
    end
    bus.DataOut <= mem[bus.address];
  end

  int n_chk = 0;
  int n_pass = 0;
  int org [2];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic load_img();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    wlog.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.begin_spawn = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    org[0] = 0;
    org[1] = 0;
  endtask

  // Model: search region from origin for first slot with status bit0 clear
  task automatic do_spawn(input bit en, input logic [7:0] x,
                          input logic [6:0] y, input logic [3:0] mv,
                          input bit drop);
    int n, b, a, first, eslot, lat, cyc;
    bit efail, valid;
    logic [15:0] ew [$];
    n = en ? ES : PS;
    b = en ? 4 * PS : 0;
    efail = 1'b1;
    eslot = 0;
    first = 0;
    valid = (x <= 8'd159) && (y <= 7'd119);
    lat = 1;
    if (valid) begin
      lat = 3 * n + 1;
      first = b + 4 * org[en];
      for (int s = 0; s < n; s++) begin
        int k;
        k = (org[en] + s) % n;
        if (!img[b + 4 * k][0]) begin
          eslot = k;
          lat = 3 * (s + 1) + 5;
          efail = 1'b0;
          break;
        end
      end
    end
    load_img();
    if (!efail) begin
      a = b + 4 * eslot;
      ew.push_back({8'(a + 1), 4'b0, mv});
      ew.push_back({8'(a + 2), x});
      ew.push_back({8'(a + 3), 1'b0, y});
      ew.push_back({8'(a), 8'h01});
      img[a + 1] = {4'b0, mv};
      img[a + 2] = x;
      img[a + 3] = {1'b0, y};
      img[a]     = 8'h01;
`ifdef SPAWN_ROTATE_EN
      org[en] = (eslot + 1) % n;
`endif
    end
    bus.spawn_enemy = en;
    bus.spawn_x = x;
    bus.spawn_y = y;
    bus.spawn_move = mv;
    bus.begin_spawn = 1'b1;
    cyc = 0;
    while (1) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1 && valid) chk("first_addr", bus.address, first);
      if (bus.done || cyc > 400) break;
      if (drop && cyc == 2) bus.begin_spawn = 1'b0;
    end
    chk("done_seen", bus.done, 1'b1);
    chk("latency", cyc, lat);
    chk("fail", bus.fail, efail);
    if (!efail) chk("slot", bus.slot, eslot + (en ? PS : 0));
    chk("nwrites", wlog.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wlog.size(); i++)
      chk("write", wlog[i], ew[i]);
    @(negedge clk);
    bus.begin_spawn = 1'b0;
    @(posedge clk);
    #1;
    chk("done_clear", bus.done, 1'b0);
  endtask

  initial begin
    int cyc;
    bus.begin_spawn = 1'b0;
    bus.spawn_enemy = 1'b0;
    bus.spawn_x = 8'd0;
    bus.spawn_y = 7'd0;
    bus.spawn_move = 4'd0;
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    org[0] = 0;
    org[1] = 0;

    #2 reset = 1'b1;
    #1;
    chk("rst_address", bus.address, 8'd0);
    chk("rst_wdata", bus.WriteData, 8'd0);
    chk("rst_ramwrite", bus.RamWrite, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_fail", bus.fail, 1'b0);
    chk("rst_slot", bus.slot, 6'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    do_spawn(1'b0, 8'd10, 7'd20, 4'b1000, 1'b0);
    do_reset();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    img[0] = 8'h01;
    img[4] = 8'h01;
    img[8] = 8'h01;
    do_spawn(1'b0, 8'd77, 7'd5, 4'b0110, 1'b0);
    for (int s = 0; s < ES; s++) img[4 * PS + 4 * s] = 8'h01;
    do_spawn(1'b1, 8'd3, 7'd4, 4'b0001, 1'b0);
    do_spawn(1'b0, 8'd160, 7'd4, 4'b0001, 1'b0);
    do_spawn(1'b1, 8'd159, 7'd120, 4'b0001, 1'b0);
    do_spawn(1'b0, 8'd159, 7'd119, 4'b1111, 1'b1);

    // Enemy: only the very last slot free (addresses 252..255)
    for (int s = 0; s < ES; s++) img[4 * PS + 4 * s] = 8'h01;
    img[252] = 8'h00;
    do_spawn(1'b1, 8'd1, 7'd2, 4'b0100, 1'b0);

    for (int it = 0; it < 40; it++) begin
      int pct;
      pct = (it % 3 == 0) ? 50 : ((it % 3 == 1) ? 90 : 100);
      for (int s = 0; s < PS + ES; s++)
        img[4 * s] = {7'($urandom), 1'($urandom_range(0, 99) < pct)};
      do_spawn(1'($urandom), 8'($urandom_range(0, 170)),
               7'($urandom_range(0, 127)), 4'($urandom),
               $urandom_range(0, 3) == 0);
    end

    do_reset();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    load_img();
    @(negedge clk);
    bus.spawn_enemy = 1'b0;
    bus.spawn_x = 8'd33;
    bus.spawn_y = 7'd44;
    bus.spawn_move = 4'd5;
    bus.begin_spawn = 1'b1;
    cyc = 0;
    while (!(bus.RamWrite && bus.address == 8'd2) && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("wx_reached", cyc < 50, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_ramwrite", bus.RamWrite, 1'b0);
    chk("midrst_address", bus.address, 8'd0);
    chk("midrst_done", bus.done, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_status", mem[0], 8'h00);
    chk("midrst_x", mem[2], 8'h00);
    chk("midrst_move", mem[1], 8'h05);
    bus.begin_spawn = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    org[0] = 0;
    org[1] = 0;

`ifdef SPAWN_ROTATE_EN
    do_reset();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
    do_spawn(1'b0, 8'd1, 7'd1, 4'b1000, 1'b0);
    do_spawn(1'b0, 8'd2, 7'd2, 4'b0100, 1'b0);
    for (int s = 0; s < ES; s++) img[4 * PS + 4 * s] = 8'h01;
    img[4 * PS + 4 * 2] = 8'h00;
    do_spawn(1'b1, 8'd5, 7'd6, 4'b0010, 1'b0);
    do_spawn(1'b1, 8'd5, 7'd6, 4'b0010, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
